// File: rtl/port_bus_master.sv
// port_bus_master: scripted initiator for a KCPSM6-style port bus.
// Commands are queued in a small FIFO and replayed as write/read strobe
// cycles; read data is returned as a one-cycle response pulse, and the
// peripheral interrupt line is acknowledged between transactions.
module port_bus_master #(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_port,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       k_write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       interrupt_ack,
    output logic [7:0] irq_count,
    output logic       busy
);

    localparam int          AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]  LAT  = 2'(READ_LATENCY);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_READ_WAIT = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    // Entry layout: {rd, port, data}
    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    state;
    logic [1:0]    wait_cnt;
    logic          int_prev, irq_pending;
    logic          push, pop, irq_rise;
    logic [16:0]   head;

    assign cmd_ready      = (count != FULL);
    assign push           = cmd_valid & cmd_ready;
    assign pop            = (state == S_IDLE) & ~irq_pending & (count != '0);
    assign head           = mem[rd_ptr];
    assign irq_rise       = interrupt & ~int_prev;

    assign write_strobe   = (state == S_WRITE);
    assign read_strobe    = (state == S_READ);
    assign interrupt_ack  = (state == S_ACK);
    assign k_write_strobe = 1'b0;
    assign busy           = (state != S_IDLE) | (count != '0);

    // Command storage; contents need no reset, validity lives in count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_rd, cmd_port, cmd_data};
    end

    // FIFO pointers and occupancy; power-of-2 depth makes pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Interrupt edge capture; an edge landing in the ACK cycle keeps it pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_prev    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            int_prev    <= interrupt;
            irq_pending <= irq_rise | (irq_pending & (state != S_ACK));
        end
    end

    // Bus sequencer: interrupts win over queued commands in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            port_id   <= '0;
            out_port  <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_port  <= '0;
            rsp_data  <= '0;
            irq_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (irq_pending) begin
                        state <= S_ACK;
                    end else if (pop) begin
                        port_id <= head[15:8];
                        if (head[16]) begin
                            state <= S_READ;
                        end else begin
                            out_port <= head[7:0];
                            state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_READ: begin
                    wait_cnt <= LAT;
                    state    <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        rsp_data  <= in_port;
                        rsp_port  <= port_id;
                        rsp_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    irq_count <= irq_count + 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
